// File: rtl/mure_pkg.sv
`default_nettype none
// mure_pkg: shared types and widths for the instruction-block generator.
package mure_pkg;

  localparam int XLEN        = 32;
  localparam int IRETIRE_LEN = 8;
  localparam int ITYPE_LEN   = 4;
  localparam int CAUSE_LEN   = 5;
  localparam int PRIV_LEN    = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic                 compressed;
    logic [ITYPE_LEN-1:0] itype;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } fifo_entry_s;

  // Instruction length in half-words.
  function automatic logic [1:0] lane_len(input logic compressed);
    return compressed ? 2'd1 : 2'd2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iblock_lane_sel.sv
`default_nettype none
// iblock_lane_sel: finds the first valid special lane at or above the lane pointer,
// and whether any valid lane remains above it.
module iblock_lane_sel #(
  parameter int NRET = 2,
  parameter int LP_W = 1
) (
  input  logic [NRET-1:0] i_valid,
  input  logic [NRET-1:0] i_special,
  input  logic [LP_W-1:0] i_lane_ptr,
  output logic            o_found,
  output logic [LP_W-1:0] o_idx,
  output logic            o_tail_valid
);

  always_comb begin
    o_found      = 1'b0;
    o_idx        = '0;
    o_tail_valid = 1'b0;
    // Descending scan so the lowest matching lane wins.
    for (int i = NRET - 1; i >= 0; i--) begin
      if ((LP_W'(i) >= i_lane_ptr) && i_valid[i] && i_special[i]) begin
        o_found = 1'b1;
        o_idx   = LP_W'(i);
      end
    end
    for (int j = 0; j < NRET; j++) begin
      if (o_found && (LP_W'(j) > o_idx) && i_valid[j]) begin
        o_tail_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/iblock_gen.sv
`default_nettype none
// iblock_gen: folds retired-instruction lane groups into trace instruction blocks.
// Optional IBLOCK_PRIV_SPLIT_EN closes an open block on a privilege change.
module iblock_gen
  import mure_pkg::*;
#(
  parameter int NRET        = 2,
  parameter int IRETIRE_LEN = mure_pkg::IRETIRE_LEN
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  fifo_entry_s [NRET-1:0]        entries_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [IRETIRE_LEN-1:0]        iretire_o,
  output logic                          ilastsize_o,
  output logic [ITYPE_LEN-1:0]          itype_o,
  output logic [CAUSE_LEN-1:0]          cause_o,
  output logic [XLEN-1:0]               tval_o,
  output logic [PRIV_LEN-1:0]           priv_o,
  output logic [XLEN-1:0]               iaddr_o
);

  localparam int                   LP_W     = (NRET > 1) ? $clog2(NRET) : 1;
  localparam logic [IRETIRE_LEN:0] IRET_MAX = {1'b0, {IRETIRE_LEN{1'b1}}};
`ifdef IBLOCK_PRIV_SPLIT_EN
  localparam bit PRIV_SPLIT = 1'b1;
`else
  localparam bit PRIV_SPLIT = 1'b0;
`endif

  state_e                 r_state;
  logic [LP_W-1:0]        r_lane_ptr;
  logic [XLEN-1:0]        r_iaddr_q;
  logic [IRETIRE_LEN-1:0] r_iretire_q;
  logic                   r_lastc_q;
  logic [PRIV_LEN-1:0]    r_priv_q;

  logic                   r_out_valid;
  logic [IRETIRE_LEN-1:0] r_out_iretire;
  logic                   r_out_ilastsize;
  logic [ITYPE_LEN-1:0]   r_out_itype;
  logic [CAUSE_LEN-1:0]   r_out_cause;
  logic [XLEN-1:0]        r_out_tval;
  logic [PRIV_LEN-1:0]    r_out_priv;
  logic [XLEN-1:0]        r_out_iaddr;

  logic [NRET-1:0]        w_lane_valid;
  logic [NRET-1:0]        w_lane_special;
  logic                   w_found;
  logic [LP_W-1:0]        w_sel_idx;
  logic                   w_tail_valid;
  logic [LP_W-1:0]        w_limit;

  state_e                 w_state_n;
  logic [XLEN-1:0]        w_iaddr_n;
  logic [IRETIRE_LEN-1:0] w_iret_n;
  logic                   w_lastc_n;
  logic [PRIV_LEN-1:0]    w_priv_n;
  logic [IRETIRE_LEN:0]   w_sum;
  logic                   w_split;
  logic                   w_brk;
  logic [LP_W-1:0]        w_brk_lane;

  logic                   w_emit;
  logic [IRETIRE_LEN-1:0] w_e_iretire;
  logic                   w_e_ilastsize;
  logic [ITYPE_LEN-1:0]   w_e_itype;
  logic [CAUSE_LEN-1:0]   w_e_cause;
  logic [XLEN-1:0]        w_e_tval;
  logic [PRIV_LEN-1:0]    w_e_priv;
  logic [XLEN-1:0]        w_e_iaddr;

  logic                   w_group_done;
  logic                   w_can_emit;
  logic                   w_go;
  logic [LP_W-1:0]        w_ptr_n;

  generate
    for (genvar g = 0; g < NRET; g++) begin : g_lane
      assign w_lane_valid[g]   = entries_i[g].valid;
      assign w_lane_special[g] = |entries_i[g].itype;
    end
  endgenerate

  iblock_lane_sel #(
    .NRET (NRET),
    .LP_W (LP_W)
  ) u_lane_sel (
    .i_valid      (w_lane_valid),
    .i_special    (w_lane_special),
    .i_lane_ptr   (r_lane_ptr),
    .o_found      (w_found),
    .o_idx        (w_sel_idx),
    .o_tail_valid (w_tail_valid)
  );

  assign w_limit = w_found ? w_sel_idx : LP_W'(NRET - 1);

  // Walk lanes lane_ptr..limit; a block break stops the walk at the breaking lane,
  // which is left unconsumed so it opens the next block on a later cycle.
  always_comb begin
    w_state_n     = r_state;
    w_iaddr_n     = r_iaddr_q;
    w_iret_n      = r_iretire_q;
    w_lastc_n     = r_lastc_q;
    w_priv_n      = r_priv_q;
    w_sum         = '0;
    w_split       = 1'b0;
    w_brk         = 1'b0;
    w_brk_lane    = '0;
    w_emit        = 1'b0;
    w_e_iretire   = '0;
    w_e_ilastsize = 1'b0;
    w_e_itype     = '0;
    w_e_cause     = '0;
    w_e_tval      = '0;
    w_e_priv      = '0;
    w_e_iaddr     = '0;
    for (int i = 0; i < NRET; i++) begin
      if (!w_brk && entries_i[i].valid &&
          (LP_W'(i) >= r_lane_ptr) && (LP_W'(i) <= w_limit)) begin
        w_sum   = {1'b0, w_iret_n} + (IRETIRE_LEN + 1)'(lane_len(entries_i[i].compressed));
        w_split = PRIV_SPLIT && (entries_i[i].itype == '0) && (entries_i[i].priv != w_priv_n);
        if ((w_state_n == COUNT) && ((w_sum > IRET_MAX) || w_split)) begin
          w_brk         = 1'b1;
          w_brk_lane    = LP_W'(i);
          w_emit        = 1'b1;
          w_e_iretire   = w_iret_n;
          w_e_ilastsize = !w_lastc_n;
          w_e_priv      = w_priv_n;
          w_e_iaddr     = w_iaddr_n;
          w_state_n     = IDLE;
          w_iret_n      = '0;
        end else begin
          if (w_state_n == IDLE) begin
            w_state_n = COUNT;
            w_iaddr_n = entries_i[i].pc;
            w_iret_n  = '0;
            w_priv_n  = entries_i[i].priv;
          end
          w_iret_n  = w_iret_n + IRETIRE_LEN'(lane_len(entries_i[i].compressed));
          w_lastc_n = entries_i[i].compressed;
          if (entries_i[i].itype != '0) begin
            w_emit        = 1'b1;
            w_e_iretire   = w_iret_n;
            w_e_ilastsize = !entries_i[i].compressed;
            w_e_itype     = entries_i[i].itype;
            w_e_cause     = entries_i[i].cause;
            w_e_tval      = entries_i[i].tval;
            w_e_priv      = entries_i[i].priv;
            w_e_iaddr     = w_iaddr_n;
            w_state_n     = IDLE;
            w_iret_n      = '0;
          end
        end
      end
    end
  end

  assign w_group_done = !w_brk && (!w_found || !w_tail_valid);
  assign w_can_emit   = !r_out_valid || ready_i;
  assign w_go         = valid_i && (!w_emit || w_can_emit);
  assign ready_o      = w_go && w_group_done;
  assign w_ptr_n      = ready_o ? '0 : (w_brk ? w_brk_lane : LP_W'(w_sel_idx + 1'b1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state         <= IDLE;
      r_lane_ptr      <= '0;
      r_iaddr_q       <= '0;
      r_iretire_q     <= '0;
      r_lastc_q       <= 1'b0;
      r_priv_q        <= '0;
      r_out_valid     <= 1'b0;
      r_out_iretire   <= '0;
      r_out_ilastsize <= 1'b0;
      r_out_itype     <= '0;
      r_out_cause     <= '0;
      r_out_tval      <= '0;
      r_out_priv      <= '0;
      r_out_iaddr     <= '0;
    end else begin
      if (w_go) begin
        r_state     <= w_state_n;
        r_lane_ptr  <= w_ptr_n;
        r_iaddr_q   <= w_iaddr_n;
        r_iretire_q <= w_iret_n;
        r_lastc_q   <= w_lastc_n;
        r_priv_q    <= w_priv_n;
      end
      if (w_go && w_emit) begin
        r_out_valid     <= 1'b1;
        r_out_iretire   <= w_e_iretire;
        r_out_ilastsize <= w_e_ilastsize;
        r_out_itype     <= w_e_itype;
        r_out_cause     <= w_e_cause;
        r_out_tval      <= w_e_tval;
        r_out_priv      <= w_e_priv;
        r_out_iaddr     <= w_e_iaddr;
      end else if (ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign valid_o     = r_out_valid;
  assign iretire_o   = r_out_iretire;
  assign ilastsize_o = r_out_ilastsize;
  assign itype_o     = r_out_itype;
  assign cause_o     = r_out_cause;
  assign tval_o      = r_out_tval;
  assign priv_o      = r_out_priv;
  assign iaddr_o     = r_out_iaddr;

endmodule

`default_nettype wire

// File: tb/tb_iblock_gen.sv
`default_nettype none
// tb_iblock_gen: scoreboard bench for iblock_gen with NRET=2 and a 3-bit iretire counter.
module tb_iblock_gen;
  import mure_pkg::*;

  localparam int NRET = 2;
  localparam int IRL  = 3;
  localparam int IMAX = (1 << IRL) - 1;

  typedef struct packed {
    logic [IRL-1:0]       iretire;
    logic                 ilastsize;
    logic [ITYPE_LEN-1:0] itype;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
    logic [XLEN-1:0]      iaddr;
  } blk_t;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic                  valid_i;
  logic                  ready_o;
  fifo_entry_s [NRET-1:0] entries_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [IRL-1:0]        iretire_o;
  logic                  ilastsize_o;
  logic [ITYPE_LEN-1:0]  itype_o;
  logic [CAUSE_LEN-1:0]  cause_o;
  logic [XLEN-1:0]       tval_o;
  logic [PRIV_LEN-1:0]   priv_o;
  logic [XLEN-1:0]       iaddr_o;

  always #5 clk = ~clk;

  iblock_gen #(
    .NRET        (NRET),
    .IRETIRE_LEN (IRL)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .entries_i   (entries_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .iretire_o   (iretire_o),
    .ilastsize_o (ilastsize_o),
    .itype_o     (itype_o),
    .cause_o     (cause_o),
    .tval_o      (tval_o),
    .priv_o      (priv_o),
    .iaddr_o     (iaddr_o)
  );

  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  blk_t exp_q[$];
  blk_t popped[$];
  int   pop_cyc[$];

  // Sequential reference model of block formation.
  bit                  m_open;
  logic [XLEN-1:0]     m_iaddr;
  int                  m_iret;
  bit                  m_lastc;
  logic [PRIV_LEN-1:0] m_priv;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic fifo_entry_s mk(input int v, input logic [31:0] pc, input int c,
                                     input int it, input int pv);
    fifo_entry_s e;
    e.valid      = (v != 0);
    e.pc         = pc;
    e.compressed = (c != 0);
    e.itype      = ITYPE_LEN'(it);
    e.priv       = PRIV_LEN'(pv);
    e.cause      = (it == 0) ? '0 : pc[6:2];
    e.tval       = (it == 0) ? '0 : {pc[15:0], 16'hbeef};
    return e;
  endfunction

  function automatic blk_t get_obs();
    blk_t b;
    b.iretire   = iretire_o;
    b.ilastsize = ilastsize_o;
    b.itype     = itype_o;
    b.cause     = cause_o;
    b.tval      = tval_o;
    b.priv      = priv_o;
    b.iaddr     = iaddr_o;
    return b;
  endfunction

  task automatic model_reset();
    m_open  = 1'b0;
    m_iaddr = '0;
    m_iret  = 0;
    m_lastc = 1'b0;
    m_priv  = '0;
    exp_q.delete();
  endtask

  task automatic model_lane(input fifo_entry_s e);
    int   len;
    bit   split;
    blk_t b;
    if (!e.valid) return;
    len = e.compressed ? 1 : 2;
`ifdef IBLOCK_PRIV_SPLIT_EN
    split = (e.itype == '0) && (e.priv != m_priv);
`else
    split = 1'b0;
`endif
    if (m_open && ((m_iret + len > IMAX) || split)) begin
      b = '0;
      b.iretire   = IRL'(m_iret);
      b.ilastsize = !m_lastc;
      b.priv      = m_priv;
      b.iaddr     = m_iaddr;
      exp_q.push_back(b);
      m_open = 1'b0;
    end
    if (!m_open) begin
      m_open  = 1'b1;
      m_iaddr = e.pc;
      m_iret  = 0;
      m_priv  = e.priv;
    end
    m_iret  = m_iret + len;
    m_lastc = e.compressed;
    if (e.itype != '0) begin
      b.iretire   = IRL'(m_iret);
      b.ilastsize = !e.compressed;
      b.itype     = e.itype;
      b.cause     = e.cause;
      b.tval      = e.tval;
      b.priv      = e.priv;
      b.iaddr     = m_iaddr;
      exp_q.push_back(b);
      m_open = 1'b0;
    end
  endtask

  task automatic monitor();
    blk_t held;
    blk_t o;
    bit   hold;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      o = get_obs();
      if (rst_i) begin
        hold = 1'b0;
      end else begin
        if (hold && valid_o) chk("stable_outputs", o, held);
        if (valid_o && ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_block", o, 0);
          end else begin
            chk("block", o, exp_q.pop_front());
            popped.push_back(o);
            pop_cyc.push_back(cyc);
          end
          hold = 1'b0;
        end else begin
          hold = valid_o;
          held = o;
        end
      end
    end
  endtask

  task automatic drive_group(input fifo_entry_s e0, input fifo_entry_s e1);
    model_lane(e0);
    model_lane(e1);
    entries_i[0] = e0;
    entries_i[1] = e1;
    valid_i      = 1'b1;
  endtask

  task automatic wait_accept(input bit rnd, output int waits);
    waits = 0;
    forever begin
      if (rnd) ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ready_o) break;
      waits++;
      if (waits > 40) begin
        chk("accept_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic send(input fifo_entry_s e0, input fifo_entry_s e1);
    int w;
    drive_group(e0, e1);
    wait_accept(1'b0, w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int              w;
    int              c, v, it;
    logic [31:0]     pc;
    fifo_entry_s     inv;
    fifo_entry_s     e0, e1;
    blk_t            b;

    rst_i     = 1'b1;
    valid_i   = 1'b0;
    ready_i   = 1'b1;
    entries_i = '0;
    inv       = '0;
    model_reset();
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_ready_o", ready_o, 0);
    chk("rst_iretire_o", iretire_o, 0);
    chk("rst_iaddr_o", iaddr_o, 0);
    chk("rst_itype_o", itype_o, 0);
    @(posedge clk);
    #1;

    // Mixed-length standard lanes closed by a compressed special lane.
    send(mk(1, 'h100, 1, 0, 3), mk(1, 'h102, 0, 0, 3));
    drive_group(mk(1, 'h106, 1, 4, 3), inv);
    wait_accept(1'b0, w);
    @(negedge clk);
    chk("blk_valid_next_cycle", valid_o, 1);
    chk("blk_iaddr", iaddr_o, 'h100);
    chk("blk_iretire", iretire_o, 4);
    chk("blk_ilastsize", ilastsize_o, 0);
    chk("blk_itype", itype_o, 4);
    @(posedge clk);
    #1;

    // Two special lanes in one group.
    drive_group(mk(1, 'h200, 0, 1, 3), mk(1, 'h204, 0, 4, 3));
    wait_accept(1'b0, w);
    chk("two_special_ready_low_cycles", w, 1);
    idle(3);
    chk("two_special_consecutive", pop_cyc[$] - pop_cyc[$-1], 1);
    b = popped[$-1];
    chk("two_special_first_iaddr", b.iaddr, 'h200);
    b = popped[$];
    chk("two_special_second", {b.itype, b.iretire, b.iaddr}, {4'd4, 3'd2, 32'h204});

    // Counter overflow with a 3-bit iretire.
    send(mk(1, 'h300, 0, 0, 3), mk(1, 'h304, 0, 0, 3));
    send(mk(1, 'h308, 0, 0, 3), mk(1, 'h30c, 0, 0, 3));
    b = popped[$];
    chk("ovf_block", {b.itype, b.iretire, b.ilastsize, b.iaddr}, {4'd0, 3'd6, 1'b1, 32'h300});
    send(mk(1, 'h310, 0, 2, 3), inv);
    idle(3);
    b = popped[$];
    chk("ovf_next_block", {b.itype, b.iretire, b.iaddr}, {4'd2, 3'd4, 32'h30c});

    // Downstream back-pressure with a second block waiting.
    ready_i = 1'b0;
    send(mk(1, 'h400, 1, 3, 3), inv);
    drive_group(mk(1, 'h410, 0, 5, 3), inv);
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready_o", ready_o, 0);
      chk("stall_valid_o", valid_o, 1);
      chk("stall_iaddr_o", iaddr_o, 'h400);
      @(posedge clk);
      #1;
    end
    ready_i = 1'b1;
    wait_accept(1'b0, w);
    idle(3);
    chk("stall_no_loss", exp_q.size(), 0);
    b = popped[$];
    chk("stall_second_iaddr", b.iaddr, 'h410);

    // Reset while counting (iretire_q = 5) with an output still pending.
    ready_i = 1'b0;
    send(mk(1, 'h480, 0, 3, 1), inv);
    send(mk(1, 'h500, 1, 0, 3), mk(1, 'h502, 0, 0, 3));
    send(mk(1, 'h506, 0, 0, 3), inv);
    #2;
    rst_i = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_mid_valid_o", valid_o, 0);
    chk("rst_mid_iretire_o", iretire_o, 0);
    @(posedge clk);
    #1;
    rst_i   = 1'b0;
    ready_i = 1'b1;
    send(mk(1, 'h600, 0, 0, 3), mk(1, 'h604, 0, 4, 3));
    idle(3);
    b = popped[$];
    chk("after_rst_block", {b.iretire, b.iaddr}, {3'd4, 32'h600});

    // Privilege change between standard instructions.
    send(mk(1, 'h700, 0, 0, 3), mk(1, 'h704, 0, 0, 0));
    send(mk(1, 'h708, 0, 2, 0), inv);
    idle(3);
`ifdef IBLOCK_PRIV_SPLIT_EN
    b = popped[$-1];
    chk("priv_split_close", {b.itype, b.iretire, b.ilastsize, b.priv, b.iaddr},
        {4'd0, 3'd2, 1'b1, 2'd3, 32'h700});
    b = popped[$];
    chk("priv_split_next", {b.itype, b.iretire, b.iaddr}, {4'd2, 3'd4, 32'h704});
`else
    b = popped[$];
    chk("priv_ignored", {b.itype, b.iretire, b.priv, b.iaddr}, {4'd2, 3'd6, 2'd0, 32'h700});
`endif

    // Random groups with random back-pressure.
    pc = 32'h1000;
    for (int g = 0; g < 40; g++) begin
      c  = $urandom_range(0, 1);
      v  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      it = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
      e0 = mk(v, pc, c, it, ($urandom_range(0, 7) == 0) ? 1 : 3);
      if (v != 0) pc = pc + ((c != 0) ? 32'd2 : 32'd4);
      c  = $urandom_range(0, 1);
      v  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      it = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
      e1 = mk(v, pc, c, it, ($urandom_range(0, 7) == 0) ? 1 : 3);
      if (v != 0) pc = pc + ((c != 0) ? 32'd2 : 32'd4);
      drive_group(e0, e1);
      wait_accept(1'b1, w);
    end
    ready_i = 1'b1;
    send(mk(1, pc, 0, 1, 3), inv);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
    chk("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iblock_gen.md
IBLOCK_GEN -- requirements
Module: iblock_gen

Interface
REQ-001 SHALL have parameter NRET, default 2: retired-instruction lanes per input group (1..4).
REQ-002 SHALL have parameter IRETIRE_LEN, default mure_pkg::IRETIRE_LEN: iretire counter width, in half-word units.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk_i, input, 1: clock, rising edge.
REQ-005 SHALL have port rst_i, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port valid_i, input, 1: input group valid.
REQ-007 SHALL have port ready_o, output, 1: input group accepted when valid_i && ready_o.
REQ-008 SHALL have port entries_i, input, NRET x mure_pkg::fifo_entry_s: per-lane valid, pc, compressed, itype, cause, tval, priv; lane 0 is oldest.
REQ-009 SHALL have port valid_o, output, 1: output block valid.
REQ-010 SHALL have port ready_i, input, 1: output block consumed when valid_o && ready_i.
REQ-011 SHALL have port iretire_o, output, IRETIRE_LEN: block length in half-words.
REQ-012 SHALL have ports ilastsize_o (1), itype_o (ITYPE_LEN), cause_o (CAUSE_LEN), tval_o (XLEN), priv_o (PRIV_LEN), iaddr_o (XLEN), all outputs, meaning per block.

Function
REQ-013 SHALL hold state IDLE (no open block) or COUNT (open block), type mure_pkg::state_e.
REQ-014 SHALL hold registers lane_ptr, iaddr_q, iretire_q, lastc_q, and a one-entry output register.
REQ-015 SHALL, in one cycle, scan the lanes of the current group from lane_ptr up to and including the first valid special lane (itype != 0), or to lane NRET-1; invalid lanes are skipped.
REQ-016 SHALL add 1 to the running iretire for a compressed lane and 2 otherwise; iaddr is the pc of the first instruction of the block.
REQ-017 SHALL, in IDLE, open a block at the first valid lane; a special lane found in IDLE emits a single-instruction block.
REQ-018 SHALL, for a special lane, emit a block of {iretire including that lane, ilastsize = !compressed, itype/cause/tval/priv of that lane, iaddr}, then return to IDLE.
REQ-019 SHALL, when adding a lane would exceed 2^IRETIRE_LEN-1, first emit an itype-0 block with iretire_q and ilastsize = !lastc_q; that lane then opens a new block.
REQ-020 SHALL emit at most one block per cycle; the block is loaded into the output register, and valid_o is asserted the following cycle.
REQ-021 SHALL assert ready_o only when the scan reaches lane NRET-1 in this cycle with emission either unneeded or possible.
REQ-022 SHALL consider emission possible only when the output register is empty or being consumed in the same cycle.
REQ-023 SHALL otherwise stall: consume nothing and keep lane_ptr, or advance lane_ptr past the emitted lane with ready_o low.
REQ-024 SHALL keep output fields stable while valid_o && !ready_i.
REQ-025 SHALL reset lane_ptr to 0 on every accepted group.

Reset
REQ-026 SHALL, on reset, set state to IDLE, and lane_ptr, iaddr_q, iretire_q, lastc_q and all outputs to 0.
REQ-027 SHALL discard any partially counted block or pending output register on reset mid-operation.

Configuration
REQ-028 SHALL, with IBLOCK_PRIV_SPLIT_EN defined, close an open block as itype 0 when a valid standard lane's priv differs from the block's priv, with the lane opening the new block.
REQ-029 SHALL, without IBLOCK_PRIV_SPLIT_EN, ignore priv except on special lanes.

Structure
REQ-030 SHALL place state_e, fifo_entry_s, IRETIRE_LEN, ITYPE_LEN, CAUSE_LEN and PRIV_LEN in mure_pkg.
REQ-031 SHALL implement first-special-lane search from lane_ptr in sub-module iblock_lane_sel.

Verification
REQ-032 SHALL test NRET=2, lanes {pc 0x100 rvc, pc 0x102 rv32}, then {pc 0x106 itype 4 rvc, invalid}, and expect one block {iaddr 0x100, iretire 4, ilastsize 0, itype 4}.
REQ-033 SHALL test a group {itype 1 at 0x200, itype 4 at 0x204} and expect two blocks on consecutive cycles, with ready_o low for one cycle.
REQ-034 SHALL test IRETIRE_LEN=3 with four uncompressed standard instructions and expect an itype-0 block {iretire 6, ilastsize 1}, after which the new block starts at the 4th pc.
REQ-035 SHALL test ready_i held low for 5 cycles and expect valid_o and outputs stable, ready_o low once a second block is pending, and no loss.
REQ-036 SHALL test rst_i pulsed while in COUNT with iretire_q=5 and expect valid_o 0, and the next block to count from 0.
REQ-037 SHALL test, with IBLOCK_PRIV_SPLIT_EN, priv 3 then priv 0 standard instructions and expect an itype-0 block closed at the priv change.
